// File: rtl/scan_doubler.sv
// scan_doubler: captures 15 kHz lines into ping-pong buffers and replays each twice at 31 kHz.
// Optional SCAN_DOUBLER_SCANLINES_EN dims the second repeat of every line to 50%.
module scan_doubler (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        PCLK_EN,
    input  logic        PCLK2X_EN,
    input  logic [11:0] iRGB,
    input  logic        HBLK,
    input  logic        VBLK,
    input  logic        HSYN,
    input  logic        VSYN,
    output logic [11:0] oRGB,
    output logic        oHBLK,
    output logic        oVBLK,
    output logic        oHSYN,
    output logic        oVSYN
);
    logic [12:0] mem [2][512];
    logic        wbank, rep, hsyn_q, armed, live, vblk_d, vsyn_d;
    logic [8:0]  icnt, ocnt, oaddr;
    logic [9:0]  hlen, ilen;
    logic [5:0]  hcnt, hsw;
    logic        lstart, hrise, ostep, rep_e, vblk_e, vsyn_e, wrap, blk;
    logic [11:0] rgb, dim;

    assign lstart = PCLK_EN && hsyn_q && !HSYN;
    assign hrise  = PCLK_EN && !hsyn_q && HSYN;
    assign ilen   = {1'b0, icnt} + 10'd1;
    // A line start resyncs the read side in the same cycle, so use the post-resync view.
    assign oaddr  = lstart ? 9'd0 : ocnt;
    assign rep_e  = lstart ? 1'b0 : rep;
    assign vblk_e = lstart ? VBLK : vblk_d;
    assign vsyn_e = lstart ? VSYN : vsyn_d;
    assign wrap   = {1'b0, oaddr} == hlen - 10'd1;
    assign ostep  = PCLK2X_EN && (live || (lstart && armed));
    assign {blk, rgb} = mem[~wbank ^ lstart][oaddr];

`ifdef SCAN_DOUBLER_SCANLINES_EN
    assign dim = rep_e ? {1'b0, rgb[11:9], 1'b0, rgb[7:5], 1'b0, rgb[3:1]} : rgb;
`else
    assign dim = rgb;
`endif

    always_ff @(posedge CLK)
        if (PCLK_EN)
            mem[wbank][icnt] <= {HBLK, iRGB};

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            icnt   <= '0;
            wbank  <= 1'b0;
            hlen   <= 10'd384;
            hsw    <= 6'd32;
            hcnt   <= '0;
            hsyn_q <= 1'b0;
            armed  <= 1'b0;
            live   <= 1'b0;
            vblk_d <= 1'b1;
            vsyn_d <= 1'b1;
        end else if (PCLK_EN) begin
            hsyn_q <= HSYN;
            hcnt   <= HSYN ? 6'd0 : hcnt + {5'd0, hcnt != 6'd63};
            // An empty low run is the reset-time idle edge, not a real pulse.
            if (hrise && hcnt != 6'd0)
                hsw <= hcnt;
            if (lstart) begin
                if (ilen >= 10'd64)
                    hlen <= ilen;
                wbank  <= ~wbank;
                icnt   <= '0;
                armed  <= 1'b1;
                live   <= armed;
                vblk_d <= VBLK;
                vsyn_d <= VSYN;
            end else
                icnt <= icnt + {8'd0, icnt != 9'h1ff};
        end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            ocnt  <= '0;
            rep   <= 1'b0;
            oRGB  <= '0;
            oHBLK <= 1'b1;
            oVBLK <= 1'b1;
            oHSYN <= 1'b1;
            oVSYN <= 1'b1;
        end else begin
            if (PCLK2X_EN) begin
                ocnt <= wrap ? 9'd0 : oaddr + 9'd1;
                rep  <= rep_e ^ wrap;
            end else if (lstart) begin
                ocnt <= '0;
                rep  <= 1'b0;
            end
            if (ostep) begin
                oHBLK <= blk;
                oRGB  <= (blk || vblk_e) ? 12'h000 : dim;
                oHSYN <= oaddr >= {3'd0, hsw};
                if (oaddr == 9'd0) begin
                    oVBLK <= vblk_e;
                    oVSYN <= vsyn_e;
                end
            end
        end
endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: random and directed lines checked against a line-level reference model.
// Define SCAN_DOUBLER_SCANLINES_EN for both DUT and bench to expect dimmed second repeats.
module tb_scan_doubler;
    logic        CLK = 0, RST_N = 0, PCLK_EN = 0, PCLK2X_EN = 0;
    logic [11:0] iRGB = 0;
    logic        HBLK = 0, VBLK = 0, HSYN = 1, VSYN = 1;
    logic [11:0] oRGB;
    logic        oHBLK, oVBLK, oHSYN, oVSYN;
    int          n_cmp = 0, n_bad = 0;

`ifdef SCAN_DOUBLER_SCANLINES_EN
    localparam bit DIM = 1'b1;
`else
    localparam bit DIM = 1'b0;
`endif

    // Reference: each captured line lands in one of two alternating line stores;
    // output slot k after a line start replays entry k mod hlen of the previous line.
    logic [12:0] line_buf [2][512];
    int          wsel, cur_n, m_hlen, m_hsw, run, starts, k;
    logic        prev_hs, vb_line, vs_line;
    logic [11:0] e_rgb;
    logic        e_hblk, e_vblk, e_hsyn, e_vsyn;

    scan_doubler dut (
        .CLK(CLK), .RST_N(RST_N), .PCLK_EN(PCLK_EN), .PCLK2X_EN(PCLK2X_EN),
        .iRGB(iRGB), .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
        .oRGB(oRGB), .oHBLK(oHBLK), .oVBLK(oVBLK), .oHSYN(oHSYN), .oVSYN(oVSYN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [11:0] dimmed(input logic [11:0] px, input logic second);
        return (second && DIM) ? (px >> 1) & 12'h777 : px;
    endfunction

    task automatic model_reset();
        wsel = 0; cur_n = 0; m_hlen = 384; m_hsw = 32; run = 0; starts = 0; k = 0;
        prev_hs = 0; vb_line = 1; vs_line = 1;
        e_rgb = 0; e_hblk = 1; e_vblk = 1; e_hsyn = 1; e_vsyn = 1;
    endtask

    task automatic model_step();
        logic [12:0] ent;
        int slot, len;
        if (!RST_N) begin
            model_reset();
            return;
        end
        if (PCLK_EN) begin
            line_buf[wsel][cur_n > 511 ? 511 : cur_n] = {HBLK, iRGB};
            if (!HSYN) run = run < 63 ? run + 1 : 63;
            else begin
                if (!prev_hs && run > 0) m_hsw = run;
                run = 0;
            end
            if (prev_hs && !HSYN) begin
                len = (cur_n > 511 ? 511 : cur_n) + 1;
                if (len >= 64) m_hlen = len;
                wsel ^= 1; cur_n = 0; starts++; k = 0;
                vb_line = VBLK; vs_line = VSYN;
            end else
                cur_n++;
            prev_hs = HSYN;
        end
        if (PCLK2X_EN) begin
            if (starts >= 2) begin
                slot = k % m_hlen;
                ent = line_buf[wsel ^ 1][slot];
                e_hblk = ent[12];
                e_rgb = (ent[12] || vb_line) ? 12'h000 : dimmed(ent[11:0], ((k / m_hlen) % 2) == 1);
                e_hsyn = slot >= m_hsw;
                if (slot == 0) begin
                    e_vblk = vb_line;
                    e_vsyn = vs_line;
                end
            end
            k++;
        end
    endtask

    task automatic pixel(input logic [11:0] rgb, input logic hb, input logic vb, input logic hs, input logic vs);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            PCLK_EN = (i == 0); PCLK2X_EN = (i % 2 == 0);
            iRGB = rgb; HBLK = hb; VBLK = vb; HSYN = hs; VSYN = vs;
            @(posedge CLK);
            model_step();
            #1;
            if (PCLK2X_EN) begin
                check("rgb", oRGB, e_rgb);
                check("blk_syn", {8'h0, oHBLK, oVBLK, oHSYN, oVSYN}, {8'h0, e_hblk, e_vblk, e_hsyn, e_vsyn});
            end
        end
    endtask

    // mode 0 random, 1 ramp, 2 leading HBLK over white, 3 flat white
    task automatic run_line(input int len, input int hs, input int mode, input logic vb, input logic vs);
        logic [11:0] rgb;
        logic hb;
        for (int p = 0; p < len; p++) begin
            rgb = mode == 0 ? 12'($urandom) : mode == 1 ? 12'(p) : 12'hfff;
            hb  = mode == 0 ? ($urandom_range(0, 7) == 0) : mode == 2 ? (p < 16) : 1'b0;
            pixel(rgb, hb, vb, p >= hs, vs);
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 512; i++)
                line_buf[b][i] = 0;
        model_reset();
        repeat (3) pixel(12'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_rgb", oRGB, 12'h000);
        check("reset_ctl", {8'h0, oHBLK, oVBLK, oHSYN, oVSYN}, 12'h00f);
        RST_N = 1;
        repeat (8) pixel(12'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) run_line(384, 32, 1, 1'b0, 1'b1);
        repeat (3) run_line(320, 32, 0, 1'b0, 1'b1);
        run_line(40, 4, 0, 1'b0, 1'b1);
        repeat (2) run_line(320, 32, 0, 1'b0, 1'b1);
        repeat (2) run_line(320, 32, 2, 1'b0, 1'b1);
        run_line(320, 32, 2, 1'b1, 1'b1);
        repeat (2) run_line(320, 24, 3, 1'b0, 1'b0);
        run_line(520, 70, 0, 1'b0, 1'b1);
        repeat (6) run_line($urandom_range(300, 460), $urandom_range(8, 70), 0, 1'($urandom), 1'($urandom));
        run_line(200, 32, 0, 1'b0, 1'b1);
        RST_N = 0;
        #1;
        model_reset();
        check("rst_async_rgb", oRGB, 12'h000);
        check("rst_async_ctl", {8'h0, oHBLK, oVBLK, oHSYN, oVSYN}, 12'h00f);
        repeat (20) pixel(12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        RST_N = 1;
        repeat (4) pixel(12'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) run_line(336, 20, 0, 1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
